seq_1001: RTL and testbench



---
 rtl/seq_1001.sv | 54 +++++
 tb/tb_seq_1001.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_1001.sv
// seq_1001: Moore detector for the serial pattern 1-0-0-1; optional saturating match counter under SEQ_1001_CNT_EN
module seq_1001 #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             dout
`ifdef SEQ_1001_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;
  state_t state_q, state_d;
  logic   dout_q;
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_1001: CNT_W must be in 1..32");
  end
  // next-state: progress through 1,10,100,1001; after a hit the trailing 1 may seed the next match
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0:      state_d = din ? S1 : S0;
      S1:      state_d = din ? S1 : S2;
      S2:      state_d = din ? S1 : S3;
      S3:      state_d = din ? S4 : S0;
      S4:      state_d = din ? S1 : ((OVERLAP != 0) ? S2 : S0);
      default: state_d = S0;
    endcase
  end
  // state and detect flag registered together so dout carries no path from din
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= (state_d == S4);
    end
  end
  assign dout = dout_q;
`ifdef SEQ_1001_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (state_d == S4 && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
  // saturating hit counter, steps on the same edge that raises dout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
  assign match_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_seq_1001.sv
// tb_seq_1001: randomized and directed check of seq_1001 against a last-four-bits reference model
module tb_seq_1001;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic dout_ov, dout_no, dout_sat;
  int   total = 0;
  int   bad   = 0;
  bit   run   = 1'b0;
  bit [3:0] hist;
  int   n_rst, n_last, cnt_ov, cnt_no;
  bit   exp_ov, exp_no;
`ifdef SEQ_1001_CNT_EN
  logic [7:0] mc_ov, mc_no;
  logic [1:0] mc_sat;
  seq_1001 #(.OVERLAP(1), .CNT_W(8)) u_ov  (.clk(clk), .rst(rst), .din(din), .dout(dout_ov),  .match_cnt(mc_ov));
  seq_1001 #(.OVERLAP(0), .CNT_W(8)) u_no  (.clk(clk), .rst(rst), .din(din), .dout(dout_no),  .match_cnt(mc_no));
  seq_1001 #(.OVERLAP(1), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .din(din), .dout(dout_sat), .match_cnt(mc_sat));
`else
  seq_1001 #(.OVERLAP(1), .CNT_W(8)) u_ov  (.clk(clk), .rst(rst), .din(din), .dout(dout_ov));
  seq_1001 #(.OVERLAP(0), .CNT_W(8)) u_no  (.clk(clk), .rst(rst), .din(din), .dout(dout_no));
  seq_1001 #(.OVERLAP(1), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .din(din), .dout(dout_sat));
`endif
  always #5 clk = ~clk;
  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist = 4'b0; n_rst = 0; n_last = 0; cnt_ov = 0; cnt_no = 0; exp_ov = 1'b0; exp_no = 1'b0;
  endtask
  task automatic model_update(input bit b);
    hist = {hist[2:0], b};
    n_rst++;
    n_last++;
    exp_ov = (n_rst >= 4) && (hist == 4'b1001);
    exp_no = (n_last >= 4) && (hist == 4'b1001);
    if (exp_no) n_last = 0;
    if (exp_ov) cnt_ov++;
    if (exp_no) cnt_no++;
  endtask
  task automatic step(input bit b);
    din = b;
    @(posedge clk);
    if (rst) model_update(b);
    #1;
  endtask
  task automatic steps(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i] == "1");
  endtask
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      din = ~din;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask
  always @(negedge clk) begin
    if (run) begin
      chk("dout_ov",  dout_ov,  exp_ov);
      chk("dout_no",  dout_no,  exp_no);
      chk("dout_sat", dout_sat, exp_ov);
`ifdef SEQ_1001_CNT_EN
      chk("cnt_ov",  mc_ov,  sat(cnt_ov, 8));
      chk("cnt_no",  mc_no,  sat(cnt_no, 8));
      chk("cnt_sat", mc_sat, sat(cnt_ov, 2));
`endif
    end
  end
  initial begin
    model_reset();
    #1;
    run = 1'b1;
    do_reset(3);
    chk("reset_dout", dout_ov, 0);
`ifdef SEQ_1001_CNT_EN
    chk("reset_cnt", mc_ov, 0);
`endif
    steps("1001");
    chk("single_hit_ov", dout_ov, 1);
    chk("single_hit_no", dout_no, 1);
    step(1'b0);
    chk("single_after", dout_ov, 0);
`ifdef SEQ_1001_CNT_EN
    chk("single_cnt", mc_ov, 1);
`endif
    do_reset(1);
    steps("1001");
    chk("ov_first", dout_ov, 1);
    steps("001");
    chk("ov_second_ov", dout_ov, 1);
    chk("ov_second_no", dout_no, 0);
`ifdef SEQ_1001_CNT_EN
    chk("ov_cnt_ov", mc_ov, 2);
    chk("ov_cnt_no", mc_no, 1);
`endif
    do_reset(1);
    steps("101010101010110001");
    chk("no_false_hit", dout_ov, 0);
    chk("no_false_cnt_model", cnt_ov, 0);
    do_reset(1);
    steps("100");
    do_reset(1);
    step(1'b1);
    chk("midseq_reset", dout_ov, 0);
    do_reset(1);
    steps("1001");
    chk("async_pre", dout_ov, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_drop", dout_ov, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    steps("1001001001001001");
    chk("sat_last_hit", dout_sat, 1);
`ifdef SEQ_1001_CNT_EN
    chk("sat_cnt2", mc_sat, 3);
    chk("sat_cnt8", mc_ov, 5);
`endif
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else step(1'($urandom_range(0, 1)));
    end
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
